// File: rtl/coor_pkg.sv
// Shared constants, types and helpers for the coordinate rotation pipeline.
package coor_pkg;

   localparam int unsigned ANGLE_W  = 10;
   localparam int unsigned LUT_FRAC = 8;
   localparam int unsigned TRIG_W   = LUT_FRAC + 2;
   localparam int unsigned ONE      = 1 << LUT_FRAC;

   // Latched angle reload request
   typedef struct packed {
      logic signed [ANGLE_W-1:0] angle;
      logic                      bypass;
   } cfg_req_t;

   // Signed product width: (coord_w+1)-bit delta times (trig_frac+2)-bit coefficient
   function automatic int unsigned prod_w(input int unsigned coord_w, input int unsigned trig_frac);
      return coord_w + trig_frac + 3;
   endfunction

endpackage

// File: rtl/coor_rotate_pipe_trig_lut.sv
// Registered Q8 sin/cos lookup: quarter-wave table with quadrant folding.
module trig_lut_q8
   import coor_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [ANGLE_W-1:0] deg,
   output logic signed [TRIG_W-1:0]  sin_q,
   output logic signed [TRIG_W-1:0]  cos_q
);

   // round(256 * sin(d)) for d = 0..90
   localparam int QW [0:90] = '{
      0,   4,   9,   13,  18,  22,  27,  31,  36,  40,
      44,  49,  53,  58,  62,  66,  71,  75,  79,  83,
      88,  92,  96,  100, 104, 108, 112, 116, 120, 124,
      128, 132, 136, 139, 143, 147, 150, 154, 158, 161,
      165, 168, 171, 175, 178, 181, 184, 187, 190, 193,
      196, 199, 202, 204, 207, 210, 212, 215, 217, 219,
      222, 224, 226, 228, 230, 232, 234, 236, 237, 239,
      241, 242, 243, 245, 246, 247, 248, 249, 250, 251,
      252, 253, 254, 254, 255, 255, 255, 256, 256, 256,
      256
   };

   function automatic logic signed [TRIG_W-1:0] qw(input int idx);
      return TRIG_W'(QW[7'(idx)]);
   endfunction

   int                       d_c;
   logic signed [TRIG_W-1:0] sin_c;
   logic signed [TRIG_W-1:0] cos_c;

   // Reduce the angle into 0..359 and fold into the first quadrant
   always_comb begin
      d_c   = int'(deg);
      sin_c = '0;
      cos_c = '0;
      if (d_c < 0) begin
         d_c = d_c + 360;
      end else if (d_c >= 360) begin
         d_c = d_c - 360;
      end
      if (d_c < 90) begin
         sin_c = qw(d_c);
         cos_c = qw(90 - d_c);
      end else if (d_c < 180) begin
         sin_c = qw(180 - d_c);
         cos_c = -qw(d_c - 90);
      end else if (d_c < 270) begin
         sin_c = -qw(d_c - 180);
         cos_c = -qw(270 - d_c);
      end else begin
         sin_c = -qw(360 - d_c);
         cos_c = qw(d_c - 270);
      end
   end

   // One-cycle registered lookup
   always_ff @(posedge clk) begin
      if (rst) begin
         sin_q <= '0;
         cos_q <= TRIG_W'(ONE);
      end else begin
         sin_q <= sin_c;
         cos_q <= cos_c;
      end
   end

endmodule

// File: rtl/coor_rotate_pipe.sv
// Four-stage streaming rotation of pixel coordinates about the image centre.
module coor_rotate_pipe
   import coor_pkg::*;
#(
   parameter int unsigned IMAGE_W   = 1024,
   parameter int unsigned IMAGE_H   = 768,
   parameter int unsigned COORD_W   = 16,
   parameter int unsigned TRIG_FRAC = 8,
   parameter int unsigned TAG_W     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [ANGLE_W-1:0] angle,
   input  logic                      angle_load,
   input  logic                      cfg_bypass,
   output logic                      cfg_busy,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [COORD_W-1:0] x_in,
   input  logic signed [COORD_W-1:0] y_in,
   input  logic [TAG_W-1:0]          tag_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [COORD_W-1:0] x_out,
   output logic signed [COORD_W-1:0] y_out,
   output logic [TAG_W-1:0]          tag_out,
   output logic                      out_oob
);

   localparam int unsigned DW    = COORD_W + 1;
   localparam int unsigned TW    = TRIG_FRAC + 2;
   localparam int unsigned PW    = prod_w(COORD_W, TRIG_FRAC);
   localparam int unsigned SW    = PW + 1;
   localparam int unsigned RW    = SW - TRIG_FRAC;
   localparam int unsigned OW    = RW + 1;
   localparam int unsigned ONE_F = 1 << TRIG_FRAC;
   localparam int unsigned UP    = (TRIG_FRAC > LUT_FRAC) ? TRIG_FRAC - LUT_FRAC : 0;
   localparam int unsigned DN    = (TRIG_FRAC < LUT_FRAC) ? LUT_FRAC - TRIG_FRAC : 0;

   localparam logic signed [DW-1:0]      CX_D   = DW'(IMAGE_W / 2);
   localparam logic signed [DW-1:0]      CY_D   = DW'(IMAGE_H / 2);
   localparam logic signed [OW-1:0]      CX_O   = OW'(IMAGE_W / 2);
   localparam logic signed [OW-1:0]      CY_O   = OW'(IMAGE_H / 2);
   localparam logic signed [OW-1:0]      W_O    = OW'(IMAGE_W);
   localparam logic signed [OW-1:0]      H_O    = OW'(IMAGE_H);
   localparam logic signed [SW-1:0]      RND    = SW'(ONE_F / 2);
   localparam logic signed [ANGLE_W-1:0] DEG360 = ANGLE_W'(360);

   // ---------------- angle reload path ----------------
   cfg_req_t              req_c;
   cfg_req_t              req_q;
   logic                  ld1_q;
   logic                  ld2_q;
   logic signed [TRIG_W-1:0] lut_sin;
   logic signed [TRIG_W-1:0] lut_cos;
   logic signed [TW-1:0]  sin_n_c;
   logic signed [TW-1:0]  cos_n_c;
   logic signed [TW-1:0]  sin_q;
   logic signed [TW-1:0]  cos_q;
   logic                  byp_q;

   // Negative angles fold to angle+360 before latching
   always_comb begin
      req_c.angle  = angle[ANGLE_W-1] ? angle + DEG360 : angle;
      req_c.bypass = cfg_bypass;
   end

   trig_lut_q8 u_lut (
      .clk   (clk),
      .rst   (rst),
      .deg   (req_q.angle),
      .sin_q (lut_sin),
      .cos_q (lut_cos)
   );

   // The table is Q8; rescale to the configured fraction width
   assign sin_n_c = TW'((int'(lut_sin) <<< UP) >>> DN);
   assign cos_n_c = TW'((int'(lut_cos) <<< UP) >>> DN);

   // Latch request, track the two-cycle lookup, commit coefficients; a reload restarts the sequence
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q    <= '0;
         ld1_q    <= 1'b0;
         ld2_q    <= 1'b0;
         cfg_busy <= 1'b0;
         sin_q    <= '0;
         cos_q    <= TW'(ONE_F);
         byp_q    <= 1'b0;
      end else begin
         ld1_q    <= angle_load;
         ld2_q    <= ld1_q && !angle_load;
         cfg_busy <= angle_load || ld1_q;
         if (angle_load) begin
            req_q <= req_c;
         end
         if (ld2_q) begin
            sin_q <= sin_n_c;
            cos_q <= cos_n_c;
            byp_q <= req_q.bypass;
         end
      end
   end

   // ---------------- data pipeline ----------------
   logic adv_c;
   assign adv_c    = !out_valid || out_ready;
   assign in_ready = adv_c;

   logic                 s1_v;
   logic signed [DW-1:0] s1_dx;
   logic signed [DW-1:0] s1_dy;
   logic [TAG_W-1:0]     s1_tag;

   logic                 s2_v;
   logic                 s2_byp;
   logic signed [PW-1:0] s2_xc;
   logic signed [PW-1:0] s2_xs;
   logic signed [PW-1:0] s2_yc;
   logic signed [PW-1:0] s2_ys;
   logic signed [DW-1:0] s2_dx;
   logic signed [DW-1:0] s2_dy;
   logic [TAG_W-1:0]     s2_tag;

   logic signed [SW-1:0] xs_c;
   logic signed [SW-1:0] ys_c;
   logic                 s3_v;
   logic signed [RW-1:0] s3_xr;
   logic signed [RW-1:0] s3_yr;
   logic [TAG_W-1:0]     s3_tag;

   logic signed [OW-1:0] xo_c;
   logic signed [OW-1:0] yo_c;
   logic                 oob_c;

   // S1: coordinates relative to the image centre
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v   <= 1'b0;
         s1_dx  <= '0;
         s1_dy  <= '0;
         s1_tag <= '0;
      end else if (adv_c) begin
         s1_v   <= in_valid;
         s1_dx  <= DW'(x_in) - CX_D;
         s1_dy  <= DW'(y_in) - CY_D;
         s1_tag <= tag_in;
      end
   end

   // S2: four products against the coefficient set active at this edge
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v   <= 1'b0;
         s2_byp <= 1'b0;
         s2_xc  <= '0;
         s2_xs  <= '0;
         s2_yc  <= '0;
         s2_ys  <= '0;
         s2_dx  <= '0;
         s2_dy  <= '0;
         s2_tag <= '0;
      end else if (adv_c) begin
         s2_v   <= s1_v;
         s2_byp <= byp_q;
         s2_xc  <= PW'(s1_dx) * PW'(cos_q);
         s2_xs  <= PW'(s1_dx) * PW'(sin_q);
         s2_yc  <= PW'(s1_dy) * PW'(cos_q);
         s2_ys  <= PW'(s1_dy) * PW'(sin_q);
         s2_dx  <= s1_dx;
         s2_dy  <= s1_dy;
         s2_tag <= s1_tag;
      end
   end

   // S3 sums with half-LSB bias for round-half-up
   always_comb begin
      xs_c = SW'(s2_xc) - SW'(s2_ys) + RND;
      ys_c = SW'(s2_xs) + SW'(s2_yc) + RND;
   end

   // S3: drop fraction bits, or pass deltas through in bypass
   always_ff @(posedge clk) begin
      if (rst) begin
         s3_v   <= 1'b0;
         s3_xr  <= '0;
         s3_yr  <= '0;
         s3_tag <= '0;
      end else if (adv_c) begin
         s3_v   <= s2_v;
         s3_xr  <= s2_byp ? RW'(s2_dx) : RW'(xs_c >>> TRIG_FRAC);
         s3_yr  <= s2_byp ? RW'(s2_dy) : RW'(ys_c >>> TRIG_FRAC);
         s3_tag <= s2_tag;
      end
   end

   // S4 full-width result and bounds test before truncation
   always_comb begin
      xo_c  = OW'(s3_xr) + CX_O;
      yo_c  = OW'(s3_yr) + CY_O;
      oob_c = xo_c[OW-1] || (xo_c >= W_O) || yo_c[OW-1] || (yo_c >= H_O);
   end

   // S4: output register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         x_out     <= '0;
         y_out     <= '0;
         tag_out   <= '0;
         out_oob   <= 1'b0;
      end else if (adv_c) begin
         out_valid <= s3_v;
         x_out     <= COORD_W'(xo_c);
         y_out     <= COORD_W'(yo_c);
         tag_out   <= s3_tag;
         out_oob   <= oob_c;
      end
   end

endmodule

// File: tb/tb_coor_rotate_pipe.sv
// Directed vectors plus backpressure, reload-timing, restart and reset sequences.
module tb_coor_rotate_pipe;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [9:0]  angle;
   logic               angle_load;
   logic               cfg_bypass;
   logic               cfg_busy;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] x_in;
   logic signed [15:0] y_in;
   logic [1:0]         tag_in;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] x_out;
   logic signed [15:0] y_out;
   logic [1:0]         tag_out;
   logic               out_oob;

   always #5 clk = ~clk;

   coor_rotate_pipe #(
      .IMAGE_W(1024), .IMAGE_H(768), .COORD_W(16), .TRIG_FRAC(8), .TAG_W(2)
   ) dut (
      .clk(clk), .rst(rst), .angle(angle), .angle_load(angle_load),
      .cfg_bypass(cfg_bypass), .cfg_busy(cfg_busy), .in_valid(in_valid),
      .in_ready(in_ready), .x_in(x_in), .y_in(y_in), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
      .y_out(y_out), .tag_out(tag_out), .out_oob(out_oob)
   );

   typedef struct {
      logic               ld;
      logic signed [9:0]  ang;
      logic               byp;
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] ex;
      logic signed [15:0] ey;
      logic               eoob;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Pulse angle_load, then wait (bounded) for cfg_busy to drop
   task automatic load_angle(input logic signed [9:0] a, input logic b);
      int k;
      @(negedge clk);
      angle = a; cfg_bypass = b; angle_load = 1'b1;
      @(negedge clk);
      angle_load = 1'b0;
      #1;
      check("busy_after_load", longint'(cfg_busy), 1);
      k = 0;
      while (cfg_busy && k < 20) begin
         @(negedge clk);
         k++;
         #1;
      end
      check("busy_cycles", k, 2);
   endtask

   // One sample in, bounded wait for it, check latency, values and single delivery
   task automatic send_check(input string nm, input logic signed [15:0] x, input logic signed [15:0] y,
                             input logic [1:0] tg, input logic signed [15:0] ex,
                             input logic signed [15:0] ey, input logic eo);
      int k;
      @(negedge clk);
      x_in = x; y_in = y; tag_in = tg; in_valid = 1'b1;
      #1;
      check({nm, "_in_ready"}, longint'(in_ready), 1);
      k = 0;
      while (k < 12) begin
         @(negedge clk);
         in_valid = 1'b0;
         k++;
         #1;
         if (out_valid) break;
      end
      check({nm, "_latency"}, k, 4);
      check({nm, "_x"}, longint'(x_out), longint'(ex));
      check({nm, "_y"}, longint'(y_out), longint'(ey));
      check({nm, "_oob"}, longint'(out_oob), longint'(eo));
      check({nm, "_tag"}, longint'(tag_out), longint'(tg));
      @(negedge clk);
      #1;
      check({nm, "_single"}, longint'(out_valid), 0);
   endtask

   initial begin
      int sent;
      int got;

      rst = 1'b1; angle = '0; angle_load = 1'b0; cfg_bypass = 1'b0;
      in_valid = 1'b0; x_in = '0; y_in = '0; tag_in = '0; out_ready = 1'b1;

      //             ld    ang        byp   x          y          ex         ey          oob
      vecs[0]  = '{1'b0, 10'sd0,   1'b0, 16'sd100,  16'sd200,  16'sd100,  16'sd200,   1'b0};
      vecs[1]  = '{1'b1, 10'sd90,  1'b0, 16'sd600,  16'sd384,  16'sd512,  16'sd472,   1'b0};
      vecs[2]  = '{1'b0, 10'sd90,  1'b0, 16'sd0,    16'sd0,    16'sd896,  -16'sd128,  1'b1};
      vecs[3]  = '{1'b1, 10'sd180, 1'b0, 16'sd600,  16'sd400,  16'sd424,  16'sd368,   1'b0};
      vecs[4]  = '{1'b1, 10'sd45,  1'b0, 16'sd522,  16'sd384,  16'sd519,  16'sd391,   1'b0};
      vecs[5]  = '{1'b1, -10'sd90, 1'b0, 16'sd600,  16'sd384,  16'sd512,  16'sd296,   1'b0};
      vecs[6]  = '{1'b1, 10'sd450, 1'b0, 16'sd600,  16'sd384,  16'sd512,  16'sd472,   1'b0};
      vecs[7]  = '{1'b1, 10'sd90,  1'b1, 16'sd37,   -16'sd5,   16'sd37,   -16'sd5,    1'b1};
      vecs[8]  = '{1'b1, 10'sd0,   1'b0, 16'sd1023, 16'sd767,  16'sd1023, 16'sd767,   1'b0};
      vecs[9]  = '{1'b0, 10'sd0,   1'b0, 16'sd1024, 16'sd0,    16'sd1024, 16'sd0,     1'b1};
      vecs[10] = '{1'b0, 10'sd0,   1'b0, 16'sd0,    16'sd767,  16'sd0,    16'sd767,   1'b0};
      vecs[11] = '{1'b0, 10'sd0,   1'b0, 16'sd512,  16'sd768,  16'sd512,  16'sd768,   1'b1};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_in_ready",  longint'(in_ready), 1);
      check("rst_cfg_busy",  longint'(cfg_busy), 0);
      check("rst_x_out",     longint'(x_out), 0);
      check("rst_y_out",     longint'(y_out), 0);
      check("rst_tag_oob",   longint'({tag_out, out_oob}), 0);

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].ld) load_angle(vecs[i].ang, vecs[i].byp);
         send_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, 2'(i),
                    vecs[i].ex, vecs[i].ey, vecs[i].eoob);
      end

      // Backpressure: 6 samples at angle 0, downstream stalls 5 cycles mid-stream
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 5 && cyc < 10);
         in_valid  = (sent < 6);
         x_in      = 16'(200 + 7 * sent);
         y_in      = 16'(300 + 3 * sent);
         tag_in    = 2'(sent);
         #1;
         if (!out_ready) check("bp_in_ready_stall", longint'(in_ready), 0);
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            check("bp_x",   longint'(x_out), 200 + 7 * got);
            check("bp_y",   longint'(y_out), 300 + 3 * got);
            check("bp_tag", longint'(tag_out), got % 4);
            got++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_sent", sent, 6);
      check("bp_got", got, 6);
      repeat (6) begin
         @(negedge clk);
         #1;
         check("bp_no_extra", longint'(out_valid), 0);
      end

      // Reload timing: sample before the load keeps angle 0, sample 3 cycles after uses 90
      got = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         in_valid   = (cyc == 0 || cyc == 4);
         x_in       = 16'sd600;
         y_in       = 16'sd384;
         tag_in     = (cyc == 0) ? 2'd1 : 2'd2;
         angle      = 10'sd90;
         cfg_bypass = 1'b0;
         angle_load = (cyc == 1);
         #1;
         if (cyc == 2 || cyc == 3) check("rl_busy_hi", longint'(cfg_busy), 1);
         if (cyc == 4) check("rl_busy_lo", longint'(cfg_busy), 0);
         if (out_valid) begin
            if (got == 0) begin
               check("rl_old_x", longint'(x_out), 600);
               check("rl_old_y", longint'(y_out), 384);
               check("rl_old_tag", longint'(tag_out), 1);
            end else begin
               check("rl_new_x", longint'(x_out), 512);
               check("rl_new_y", longint'(y_out), 472);
               check("rl_new_tag", longint'(tag_out), 2);
            end
            got++;
         end
      end
      in_valid   = 1'b0;
      angle_load = 1'b0;
      check("rl_count", got, 2);

      // Back-to-back loads: the second one wins and extends cfg_busy
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         angle_load = (cyc < 2);
         angle      = (cyc == 0) ? 10'sd180 : 10'sd90;
         #1;
         if (cyc >= 1 && cyc <= 3) check("rs_busy_hi", longint'(cfg_busy), 1);
         if (cyc == 4) check("rs_busy_lo", longint'(cfg_busy), 0);
      end
      angle_load = 1'b0;
      send_check("restart", 16'sd600, 16'sd384, 2'd3, 16'sd512, 16'sd472, 1'b0);

      // Reset with three samples in flight
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         in_valid = 1'b1;
         x_in     = 16'(600 + cyc);
         y_in     = 16'sd384;
         tag_in   = 2'd3;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", longint'(out_valid), 0);
      check("mid_rst_x_out",     longint'(x_out), 0);
      check("mid_rst_y_out",     longint'(y_out), 0);
      check("mid_rst_tag_oob",   longint'({tag_out, out_oob}), 0);
      check("mid_rst_in_ready",  longint'(in_ready), 1);
      check("mid_rst_busy",      longint'(cfg_busy), 0);
      repeat (8) begin
         @(negedge clk);
         #1;
         check("mid_rst_no_stale", longint'(out_valid), 0);
      end
      send_check("post_rst", 16'sd600, 16'sd384, 2'd1, 16'sd600, 16'sd384, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/coor_rotate_pipe.md
Name: coor_rotate_pipe

Overview:
- Streaming, fully pipelined rotation of pixel coordinates about the image centre.
- Sits between the pixel coordinate generator and the frame-buffer address calculator in the rotation path.
- Adds configurable width, fixed-point precision, round-to-nearest, valid/ready backpressure, angle reload with bypass, sideband pass-through and out-of-bounds flagging.

Parameters:
- IMAGE_W, 1024, image width in pixels; centre CX = IMAGE_W/2.
- IMAGE_H, 768, image height in pixels; centre CY = IMAGE_H/2.
- COORD_W, 16, signed coordinate width for input and output.
- TRIG_FRAC, 8, fractional bits of sin/cos; 1.0 = 2^TRIG_FRAC.
- TAG_W, 2, sideband width (e.g. {sof, eol}), delayed with the data.

Ports:
- clk, input, 1: the only clock.
- rst, input, 1: synchronous, active-high reset.
- angle, input, 10: signed, degrees; valid range -359..359.
- angle_load, input, 1: one-cycle pulse that samples angle and cfg_bypass.
- cfg_bypass, input, 1: when the latched value is 1, output equals input (no rotation).
- cfg_busy, output, 1: high while a new angle is propagating.
- in_valid, input, 1: input sample valid.
- in_ready, output, 1: block can accept a sample.
- x_in, input, COORD_W: signed input x.
- y_in, input, COORD_W: signed input y.
- tag_in, input, TAG_W: sideband in.
- out_valid, output, 1: output sample valid.
- out_ready, input, 1: downstream accepts the sample.
- x_out, output, COORD_W: rotated x.
- y_out, output, COORD_W: rotated y.
- tag_out, output, TAG_W: sideband out.
- out_oob, output, 1: rotated point lies outside [0,IMAGE_W) x [0,IMAGE_H).

Behaviour:
- Reset: all valids 0, in_ready 1, cfg_busy 0, x_out/y_out/tag_out/out_oob 0. Coefficients reset to cos=2^TRIG_FRAC, sin=0, bypass=0.
- Pipeline: 4 stages; latency 4 cycles from input handshake to out_valid with no stall.
  - S1: dx = x_in - CX, dy = y_in - CY, width COORD_W+1.
  - S2: four products, width COORD_W+TRIG_FRAC+3.
  - S3: xr = dx*cos - dy*sin, yr = dx*sin + dy*cos; add 2^(TRIG_FRAC-1), then arithmetic shift right by TRIG_FRAC (round half up).
  - S4: add CX/CY, truncate to COORD_W, compute out_oob from the full-width value before truncation.
- Handshake: global stall. adv = !out_valid || out_ready; in_ready = adv.
  - Every stage register updates only when adv = 1; data is held while stalled.
  - No sample is lost or duplicated; order is preserved.
  - Bubbles (valid = 0) propagate normally.
- Angle reload:
  - Cycle 0: angle_load=1 registers angle/cfg_bypass.
  - Cycle 1: trig_lut_q8 output registered.
  - Cycle 2: coefficient registers updated.
  - cfg_busy is high in cycles 1-2.
  - Samples entering S2 from cycle 3 onward use the new coefficients; earlier samples use the old ones.
  - angle_load while cfg_busy=1 restarts the sequence; the last load wins.
  - Reload proceeds regardless of stall.
- Angle normalisation: negative angles map to angle+360. Values outside -359..359 are reduced mod 360 inside the LUT.
- Bypass: S3 forces xr=dx, yr=dy. Latency is unchanged and out_oob is still computed.
- rst mid-stream: all in-flight samples are discarded and outputs return to reset values the next cycle.

Decomposition:
- Shared package coor_pkg holds:
  - TRIG_W = TRIG_FRAC+2;
  - the angle width (10);
  - the function computing product width from COORD_W/TRIG_FRAC;
  - the ONE constant = 1<<TRIG_FRAC.
- One sub-module: trig_lut_q8.
  - Registered, 1-cycle latency.
  - Inputs: degrees 0..359.
  - Outputs: signed sin and cos, TRIG_W bits, round(2^TRIG_FRAC * f).
  - Built as a quarter-wave table plus quadrant folding.

Test Plan (IMAGE 1024x768, COORD_W 16, TRIG_FRAC 8, centre (512,384)):
- Angle 0 (reset coefficients), (100,200) -> (100,200) exactly 4 cycles later; out_oob=0.
- angle_load 90, wait for cfg_busy low, then (600,384) -> (512,472); (600,400) at angle 180 -> (424,368).
- Angle 90, (0,0) -> (896,-128) with out_oob=1. At angle 45 (sin=cos=181), (522,384) -> (519,391) from round-to-nearest: 1810 rounds to 7.
- Backpressure: 6 back-to-back samples, out_ready low 5 cycles mid-stream -> in_ready low during the stall; all 6 outputs in order with correct tags; none dropped or duplicated.
- angle_load 90 one cycle after a sample is accepted -> that sample uses old angle 0; a sample accepted 3 cycles after the load uses 90. cfg_bypass=1 load -> (37,-5) in gives (37,-5) out, out_oob=1.
- rst asserted with 3 samples in flight -> out_valid=0 the next cycle, coefficients back to cos=256/sin=0, no stale output after release.
